// File: rtl/op_issuer_if.sv
// op_issuer_if: bundle of all handshake and memory-port signals of op_issuer.
//   Command   : cmd_valid/cmd_ready plus latched fields cmd_meta, cmd_words,
//               cmd_has_B, cmd_has_scalar, cmd_scalar.
//   Operands  : in_valid/in_ready/in_data (all of A, then all of B).
//   Results   : out_valid/out_ready/out_data.
//   Memory    : mem_read, mem_write, mem_addr, mem_wdata, mem_rdata (rdata
//               valid the cycle after mem_read).
//   Status    : busy, done.
// Modport master is the issuer; modport slave is the host plus memory side.
interface op_issuer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 64
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [WORD_WIDTH-1:0] cmd_meta;
  logic [ADDR_WIDTH-1:0] cmd_words;
  logic                  cmd_has_B;
  logic                  cmd_has_scalar;
  logic [WORD_WIDTH-1:0] cmd_scalar;

  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;

  logic                  busy;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_meta, cmd_words, cmd_has_B, cmd_has_scalar, cmd_scalar,
    input  in_valid, in_data, out_ready, mem_rdata,
    output cmd_ready, in_ready, out_valid, out_data,
    output mem_read, mem_write, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    output cmd_valid, cmd_meta, cmd_words, cmd_has_B, cmd_has_scalar, cmd_scalar,
    output in_valid, in_data, out_ready, mem_rdata,
    input  cmd_ready, in_ready, out_valid, out_data,
    input  mem_read, mem_write, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/op_issuer.sv
// op_issuer: host-side initiator for the matrix-engine mailbox.
// Accepts one command, stores operand A (and optionally B and a scalar) in
// shared memory, posts the op/meta word, polls that word until the compute
// engine clears it, then streams the result words out and pulses done.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high
//   bus    - op_issuer_if.master: command, operand stream, result stream,
//            single memory port (one access per cycle), busy/done status.
module op_issuer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    WORD_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] OP_ADDR     = 'h0000,
  parameter logic [ADDR_WIDTH-1:0] SCALAR_ADDR = 'h0001,
  parameter logic [ADDR_WIDTH-1:0] DATAA_ADDR  = 'h0100,
  parameter logic [ADDR_WIDTH-1:0] DATAB_ADDR  = 'h0200,
  parameter logic [ADDR_WIDTH-1:0] RES_ADDR    = 'h0300,
  parameter int                    POLL_GAP    = 4
) (
  input logic          clock,
  input logic          reset,
  op_issuer_if.master  bus
);

  // WAIT_GAP reuses the word counter as its idle-cycle counter.
  localparam logic [ADDR_WIDTH-1:0] GAP_LAST = ADDR_WIDTH'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_SCALAR,
    POST_OP,
    POLL_REQ,
    POLL_CHK,
    WAIT_GAP,
    DRAIN_REQ,
    DRAIN_CAP,
    DRAIN_OUT,
    DONE
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [WORD_WIDTH-1:0] out_data_q;

  // Latched command fields
  logic [WORD_WIDTH-1:0] meta_q;
  logic [WORD_WIDTH-1:0] scalar_q;
  logic [ADDR_WIDTH-1:0] words_q;
  logic                  has_b_q;
  logic                  has_scalar_q;

  logic                  accept;
  logic                  capture;
  logic                  last;

  logic                  cmd_ready;
  logic                  in_ready;
  logic                  out_valid;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  done;

  assign last = (cnt == (words_q - 1'b1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      out_data_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) out_data_q <= bus.mem_rdata;
    end
  end

  // Command fields only matter after acceptance, so they carry no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      meta_q       <= bus.cmd_meta;
      scalar_q     <= bus.cmd_scalar;
      words_q      <= bus.cmd_words;
      has_b_q      <= bus.cmd_has_B;
      has_scalar_q <= bus.cmd_has_scalar;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept   = 1'b1;
          cnt_nx   = '0;
          // A zero-length command finishes without touching memory.
          state_nx = (bus.cmd_words == '0) ? DONE : LOAD_A;
        end
      end

      LOAD_A: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          mem_write = 1'b1;
          mem_addr  = DATAA_ADDR + cnt;
          mem_wdata = bus.in_data;
          if (last) begin
            cnt_nx = '0;
            if (has_b_q)           state_nx = LOAD_B;
            else if (has_scalar_q) state_nx = LOAD_SCALAR;
            else                   state_nx = POST_OP;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end

      LOAD_B: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          mem_write = 1'b1;
          mem_addr  = DATAB_ADDR + cnt;
          mem_wdata = bus.in_data;
          if (last) begin
            cnt_nx   = '0;
            state_nx = has_scalar_q ? LOAD_SCALAR : POST_OP;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end

      LOAD_SCALAR: begin
        mem_write = 1'b1;
        mem_addr  = SCALAR_ADDR;
        mem_wdata = scalar_q;
        cnt_nx    = '0;
        state_nx  = POST_OP;
      end

      // The op word goes last so the engine never sees a half-loaded job.
      POST_OP: begin
        mem_write = 1'b1;
        mem_addr  = OP_ADDR;
        mem_wdata = meta_q;
        cnt_nx    = '0;
        state_nx  = POLL_REQ;
      end

      POLL_REQ: begin
        mem_read = 1'b1;
        mem_addr = OP_ADDR;
        state_nx = POLL_CHK;
      end

      POLL_CHK: begin
        cnt_nx   = '0;
        state_nx = (bus.mem_rdata == '0) ? DRAIN_REQ : WAIT_GAP;
      end

      WAIT_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = POLL_REQ;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      DRAIN_REQ: begin
        mem_read = 1'b1;
        mem_addr = RES_ADDR + cnt;
        state_nx = DRAIN_CAP;
      end

      DRAIN_CAP: begin
        capture  = 1'b1;
        state_nx = DRAIN_OUT;
      end

      DRAIN_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (last) begin
            cnt_nx   = '0;
            state_nx = DONE;
          end else begin
            cnt_nx   = cnt + 1'b1;
            state_nx = DRAIN_REQ;
          end
        end
      end

      DONE: begin
        done     = 1'b1;
        cnt_nx   = '0;
        state_nx = IDLE;
      end

      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;

endmodule
